// File: rtl/tone_player.sv
// -----------------------------------------------------------------------------
// tone_player
//
// Purpose
//   Initiator side of the audio sine-ROM lookup interface. Accepts note
//   requests, drives the ROM freq_id/index inputs from a 16-bit phase
//   accumulator and reads back the ROM's freq (phase increment) and level
//   (magnitude). The sign folded away by the ROM is restored from the phase
//   MSB, and one signed sample is emitted per sample tick.
//
// Configuration
//   PWM_OUT_EN  When defined, a free-running counter and a registered
//               comparator turn the sample into a PWM bit stream on
//               pwm_out_o. When undefined, pwm_out_o is tied low.
//
// Ports
//   clk_i            system clock
//   reset_i          asynchronous, active-high reset
//   sample_tick_i    one-cycle strobe at the audio sample rate
//   note_valid_i     note request valid
//   note_id_i        0..24 = A2..A4, 31 = rest/stop, 25..30 play ROM default
//   note_ready_o     note request accepted when valid && ready
//   rom_freq_id_o    to ROM freq_id
//   rom_index_o      to ROM index (always 0..1023)
//   rom_freq_i       from ROM freq (phase increment per sample)
//   rom_level_i      from ROM level (magnitude)
//   sample_o         signed two's-complement sample
//   sample_valid_o   one-cycle strobe, sample_o updated
//   playing_o        high while the FSM is in PLAY
//   pwm_out_o        PWM audio output
//   state_o          debug view of the FSM state
//
// Handshake
//   A note is transferred on a rising clock edge where note_valid_i and
//   note_ready_o are both high. note_ready_o depends only on the FSM state,
//   never on note_valid_i, and the requester must hold note_id_i stable
//   while note_valid_i is high.
//
// Sample timing
//   The edge that samples sample_tick_i advances the phase (stage 0), the
//   next edge registers the ROM index and sign (stage 1), and the edge after
//   that registers sample_o and raises sample_valid_o (stage 2). Ticks must
//   be at least 3 cycles apart.
// -----------------------------------------------------------------------------
module tone_player #(
  parameter int BITS = 6
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            sample_tick_i,
  input  logic            note_valid_i,
  input  logic [4:0]      note_id_i,
  output logic            note_ready_o,
  output logic [4:0]      rom_freq_id_o,
  output logic [10:0]     rom_index_o,
  input  logic [15:0]     rom_freq_i,
  input  logic [BITS-1:0] rom_level_i,
  output logic [BITS:0]   sample_o,
  output logic            sample_valid_o,
  output logic            playing_o,
  output logic            pwm_out_o,
  output logic [1:0]      state_o
);

  localparam logic [4:0] NOTE_REST = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PLAY = 2'd2,
    S_PEND = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [15:0] phase_q, phase_d;
  logic [15:0] freq_q, freq_d;
  logic [4:0]  freq_id_q, freq_id_d;
  logic [4:0]  pend_id_q, pend_id_d;
  logic        from_idle_q, from_idle_d;

  logic        note_ready;
  logic        note_accept;
  logic        tick_zero;      // the sample produced by this tick is forced to 0
  logic [16:0] phase_sum;      // bit 16 is the carry out of phase[15]

  assign note_accept = note_valid_i && note_ready;
  assign phase_sum   = {1'b0, phase_q} + {1'b0, freq_q};

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    freq_d      = freq_q;
    freq_id_d   = freq_id_q;
    pend_id_d   = pend_id_q;
    from_idle_d = from_idle_q;
    note_ready  = 1'b0;
    tick_zero   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Phase is frozen; ticks still produce a (silent) sample.
        note_ready = 1'b1;
        tick_zero  = 1'b1;
        if (note_accept && (note_id_i != NOTE_REST)) begin
          freq_id_d   = note_id_i;
          from_idle_d = 1'b1;
          state_d     = S_LOAD;
        end
      end

      S_LOAD: begin
        // rom_freq_id_o already carries the new id, so rom_freq_i is the new
        // increment. A tick here still advances with the old increment, but
        // the phase clear for a fresh start takes priority.
        if (sample_tick_i) begin
          phase_d = phase_sum[15:0];
        end
        if (from_idle_q) begin
          phase_d = '0;
        end
        freq_d  = rom_freq_i;
        state_d = S_PLAY;
      end

      S_PLAY: begin
        note_ready = 1'b1;
        if (sample_tick_i) begin
          phase_d = phase_sum[15:0];
        end
        if (note_accept) begin
          pend_id_d = note_id_i;
          state_d   = S_PEND;
        end
      end

      S_PEND: begin
        // The old note keeps sounding until a positive-going zero crossing,
        // so the switch to the new note (or to silence) is click-free.
        if (sample_tick_i) begin
          phase_d = phase_sum[15:0];
          if (phase_sum[16]) begin
            if (pend_id_q == NOTE_REST) begin
              phase_d   = '0;
              freq_id_d = NOTE_REST;
              tick_zero = 1'b1;
              state_d   = S_IDLE;
            end else begin
              freq_id_d   = pend_id_q;
              from_idle_d = 1'b0;
              state_d     = S_LOAD;
            end
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      freq_q      <= '0;
      freq_id_q   <= NOTE_REST;
      pend_id_q   <= NOTE_REST;
      from_idle_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      freq_q      <= freq_d;
      freq_id_q   <= freq_id_d;
      pend_id_q   <= pend_id_d;
      from_idle_q <= from_idle_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Sample pipeline
  // ---------------------------------------------------------------------------
  logic          s1_valid_q, s1_zero_q;
  logic          s2_valid_q, s2_zero_q;
  logic [10:0]   index_q;
  logic          neg_q;
  logic [BITS:0] sample_q, sample_d;
  logic          sample_valid_q;
  logic [BITS:0] level_mag;

  assign level_mag = {1'b0, rom_level_i};

  // Sign restoration: the ROM only returns the magnitude, the half-cycle is
  // carried alongside the index as neg_q.
  always_comb begin
    sample_d = sample_q;
    if (s2_valid_q) begin
      if (s2_zero_q) begin
        sample_d = '0;
      end else if (neg_q) begin
        sample_d = -level_mag;
      end else begin
        sample_d = level_mag;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      s1_valid_q     <= 1'b0;
      s1_zero_q      <= 1'b0;
      s2_valid_q     <= 1'b0;
      s2_zero_q      <= 1'b0;
      index_q        <= '0;
      neg_q          <= 1'b0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= sample_tick_i;
      s1_zero_q  <= sample_tick_i && tick_zero;
      s2_valid_q <= s1_valid_q;
      s2_zero_q  <= s1_zero_q;
      // Index MSB is held at 0: the upper half of the ROM address space is
      // reserved. Silent ticks leave the ROM address untouched.
      if (s1_valid_q && !s1_zero_q) begin
        index_q <= {1'b0, phase_q[15:6]};
        neg_q   <= phase_q[15];
      end
      sample_valid_q <= s2_valid_q;
      sample_q       <= sample_d;
    end
  end

  // ---------------------------------------------------------------------------
  // PWM output
  // ---------------------------------------------------------------------------
`ifdef PWM_OUT_EN
  logic [BITS:0] pwm_cnt_q;
  logic          pwm_q;
  logic [BITS:0] pwm_level;

  // Two's complement to offset binary (sample + 2^BITS) is an MSB flip.
  assign pwm_level = {~sample_q[BITS], sample_q[BITS-1:0]};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pwm_cnt_q <= '0;
      pwm_q     <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + (BITS+1)'(1);
      pwm_q     <= (pwm_level > pwm_cnt_q);
    end
  end

  assign pwm_out_o = pwm_q;
`else
  assign pwm_out_o = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign note_ready_o   = note_ready;
  assign rom_freq_id_o  = freq_id_q;
  assign rom_index_o    = index_q;
  assign sample_o       = sample_q;
  assign sample_valid_o = sample_valid_q;
  assign playing_o      = (state_q == S_PLAY);
  assign state_o        = state_q;

endmodule
